reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
- Shares one single-port register bus between the write and read register-request sides of the AXI4-Lite slave front end.
- Both sides can request at the same time. The block grants one side per transfer using round-robin order, drives the register bus, and waits for the target's acknowledge.
- It returns a one-cycle acknowledge to the granted side. If the target never answers, a timeout completes the transfer with an error flag.
- Position: between the AXI4-Lite interface (request side) and the peripheral register bank (target side).

Parameters:
- ADDR_W, 4, register address width on both sides.
- TIMEOUT_CYCLES, 16, cycles in a busy state before a forced completion. 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF, value returned on rd_data when a read times out.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wr_addr  in  ADDR_W  write address, valid while wr_en=1
- wr_en  in  1  write request, level, held until wr_ack
- wr_data  in  32  write data
- wr_strb  in  4  byte enables
- wr_ack  out  1  one-cycle write completion pulse
- wr_err  out  1  timeout flag, valid only with wr_ack
- rd_addr  in  ADDR_W  read address, valid while rd_en=1
- rd_en  in  1  read request, level, held until rd_ack
- rd_data  out  32  read data, valid with rd_ack and held afterwards
- rd_ack  out  1  one-cycle read completion pulse
- rd_err  out  1  timeout flag, valid only with rd_ack
- reg_addr  out  ADDR_W  target address
- reg_wr  out  1  target write strobe, level
- reg_rd  out  1  target read strobe, level
- reg_wdata  out  32  target write data
- reg_strb  out  4  target byte enables
- reg_rdata  in  32  target read data, valid with reg_ack
- reg_ack  in  1  target completion
- busy  out  1  high when the state is not IDLE

Behaviour:
- Reset values: all outputs 0, state=IDLE, last_grant=READ (so write wins the first tie), timeout counter 0.
- All outputs are registered. No combinational path from any input to any output.
- States:
  - IDLE:
    - Only wr_en=1: latch wr_addr/wr_data/wr_strb into reg_addr/reg_wdata/reg_strb; set reg_wr=1; go to WR_BUSY.
    - Only rd_en=1: latch rd_addr into reg_addr; set reg_rd=1; go to RD_BUSY.
    - Both: grant the side opposite last_grant; update last_grant to the granted side.
    - A single request also updates last_grant.
  - WR_BUSY / RD_BUSY: the strobe stays high and the counter increments each cycle.
    - reg_ack=1: drop the strobe; go to ACK.
      - Write: set wr_ack=1, wr_err=0.
      - Read: set rd_ack=1, rd_err=0, rd_data<=reg_rdata.
    - Else if TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1: same completion, but err=1 and, for a read, rd_data<=ERR_DATA.
    - reg_ack takes precedence over the timeout when both hit in the same cycle.
  - ACK: ack/err pulse is high for exactly this cycle; clear them and the counter; go to IDLE. This cycle lets the requester drop its level request so it is not granted again.
- Latency: request sampled at edge 0, strobe high in cycle 1. With reg_ack in cycle 1, the ack pulse is in cycle 2 and the block is back in IDLE in cycle 3.
- Minimum transfer period: 3 cycles.
- reg_addr, reg_wdata and reg_strb are held stable for the whole busy phase. Changes on the request inputs during busy are ignored.
- Strobes are mutually exclusive: reg_wr and reg_rd are never both 1.
- reg_ack while IDLE or ACK: ignored.
- A request dropped mid-busy still completes and still pulses ack.
- rd_data keeps its last value until the next read completion. A write never changes it.
- Reset mid-operation: at the next edge strobes drop, the state returns to IDLE and no ack pulse is emitted.
- Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1 bit.

Test Plan:
- Single write: wr_addr=3, wr_data=32'h1234_5678, wr_strb=4'hF; target acks in cycle 2. Required: reg_wr high cycles 1–2 with those values; wr_ack=1, wr_err=0 in cycle 3; busy=0 in cycle 4.
- Single read: rd_addr=5, target returns reg_rdata=32'hCAFE_0001 with immediate ack. Required: rd_ack in cycle 2, rd_data=32'hCAFE_0001, held after the pulse.
- Simultaneous requests held for 3 transfers: grant order write, read, write. reg_wr and reg_rd are never 1 together; each ack fires once per transfer.
- Timeout: read with reg_ack never asserted, TIMEOUT_CYCLES=16. Required: reg_rd high for 16 cycles, then rd_ack=1, rd_err=1, rd_data=32'hDEAD_BEEF. Repeat with a write and check wr_err=1.
- reg_ack and timeout in the same cycle: err=0 and rd_data=reg_rdata.
- rst asserted in the 2nd busy cycle of a write: next cycle reg_wr=0, busy=0, no wr_ack. A following read completes normally, and write wins the next tie.

Source files
------------

// File: rtl/reg_bus_arbiter_if.sv
// Request side (AXI4-Lite write/read) and target side (register bank) of the
// shared register bus, bundled so the arbiter and its environment connect in one go.
interface reg_bus_arbiter_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              wr_ack;
  logic              wr_err;

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [31:0]       rd_data;
  logic              rd_ack;
  logic              rd_err;

  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr;
  logic              reg_rd;
  logic [31:0]       reg_wdata;
  logic [3:0]        reg_strb;
  logic [31:0]       reg_rdata;
  logic              reg_ack;

  logic              busy;

  // The arbiter masters the register bus and answers both requesters.
  modport master (
    input  wr_addr, wr_en, wr_data, wr_strb,
    input  rd_addr, rd_en,
    input  reg_rdata, reg_ack,
    output wr_ack, wr_err,
    output rd_data, rd_ack, rd_err,
    output reg_addr, reg_wr, reg_rd, reg_wdata, reg_strb,
    output busy
  );

  modport slave (
    output wr_addr, wr_en, wr_data, wr_strb,
    output rd_addr, rd_en,
    output reg_rdata, reg_ack,
    input  wr_ack, wr_err,
    input  rd_data, rd_ack, rd_err,
    input  reg_addr, reg_wr, reg_rd, reg_wdata, reg_strb,
    input  busy
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register bus between the write and read request
// sides; every output is registered and a hung target is released by a timeout.
module reg_bus_arbiter #(
  parameter int          ADDR_W         = 4,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input logic               clk,
  input logic               rst,
  reg_bus_arbiter_if.master bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              last_grant_rd;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic              reg_wr_q;
  logic              reg_rd_q;
  logic              wr_ack_q;
  logic              wr_err_q;
  logic              rd_ack_q;
  logic              rd_err_q;
  logic [31:0]       rd_data_q;
  logic              busy_q;
  logic              timeout_hit;
  logic              grant_wr;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  // On a tie the side that did not win last time gets the bus.
  assign grant_wr = bus.wr_en && (!bus.rd_en || last_grant_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant_rd <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      reg_wr_q      <= 1'b0;
      reg_rd_q      <= 1'b0;
      wr_ack_q      <= 1'b0;
      wr_err_q      <= 1'b0;
      rd_ack_q      <= 1'b0;
      rd_err_q      <= 1'b0;
      rd_data_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (grant_wr) begin
            addr_q        <= bus.wr_addr;
            wdata_q       <= bus.wr_data;
            strb_q        <= bus.wr_strb;
            reg_wr_q      <= 1'b1;
            last_grant_rd <= 1'b0;
            busy_q        <= 1'b1;
            state         <= WR_BUSY;
          end else if (bus.rd_en) begin
            addr_q        <= bus.rd_addr;
            reg_rd_q      <= 1'b1;
            last_grant_rd <= 1'b1;
            busy_q        <= 1'b1;
            state         <= RD_BUSY;
          end
        end

        WR_BUSY, RD_BUSY: begin
          // A real acknowledge beats a timeout landing in the same cycle.
          if (bus.reg_ack || timeout_hit) begin
            reg_wr_q <= 1'b0;
            reg_rd_q <= 1'b0;
            state    <= ACK;
            if (state == WR_BUSY) begin
              wr_ack_q <= 1'b1;
              wr_err_q <= !bus.reg_ack;
            end else begin
              rd_ack_q  <= 1'b1;
              rd_err_q  <= !bus.reg_ack;
              rd_data_q <= bus.reg_ack ? bus.reg_rdata : ERR_DATA;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ACK: begin
          wr_ack_q <= 1'b0;
          wr_err_q <= 1'b0;
          rd_ack_q <= 1'b0;
          rd_err_q <= 1'b0;
          cnt      <= '0;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_strb  = strb_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_rd    = reg_rd_q;
  assign bus.wr_ack    = wr_ack_q;
  assign bus.wr_err    = wr_err_q;
  assign bus.rd_ack    = rd_ack_q;
  assign bus.rd_err    = rd_err_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = busy_q;

  // The two target strobes share one bus and must never overlap.
  a_strobe_excl: assert property (@(posedge clk) !(reg_wr_q && reg_rd_q));
  a_ack_excl:    assert property (@(posedge clk) !(wr_ack_q && rd_ack_q));

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_reg_bus_arbiter;

  localparam int          AW  = 4;
  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  reg_bus_arbiter_if #(.ADDR_W(AW)) bus ();

  reg_bus_arbiter #(
    .ADDR_W(AW),
    .TIMEOUT_CYCLES(TO),
    .ERR_DATA(ERR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                               input logic [3:0] ws, input logic re, input logic [AW-1:0] ra,
                               input logic ack, input logic [31:0] rdata);
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.wr_strb   = ws;
    bus.rd_en     = re;
    bus.rd_addr   = ra;
    bus.reg_ack   = ack;
    bus.reg_rdata = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: one transfer in flight, counted in strobe cycles.
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wdata, e_rd_data;
  logic [3:0]    e_strb;
  logic          e_wr, e_rd, e_wr_ack, e_wr_err, e_rd_ack, e_rd_err, e_busy;
  bit            m_in_flight, m_is_read, m_last_read;
  int            m_age;

  always @(posedge clk) begin
    if (rst) begin
      {e_wr, e_rd, e_wr_ack, e_wr_err, e_rd_ack, e_rd_err, e_busy} = '0;
      e_addr = '0; e_wdata = '0; e_strb = '0; e_rd_data = '0;
      m_in_flight = 0; m_last_read = 1; m_age = 0;
    end else if (e_wr_ack || e_rd_ack) begin
      {e_wr_ack, e_wr_err, e_rd_ack, e_rd_err, e_busy} = '0;
    end else if (m_in_flight) begin
      m_age++;
      if (bus.reg_ack || (TO != 0 && m_age >= TO)) begin
        m_in_flight = 0;
        e_wr = 0;
        e_rd = 0;
        if (m_is_read) begin
          e_rd_ack  = 1;
          e_rd_err  = !bus.reg_ack;
          e_rd_data = bus.reg_ack ? bus.reg_rdata : ERR;
        end else begin
          e_wr_ack = 1;
          e_wr_err = !bus.reg_ack;
        end
      end
    end else if (bus.wr_en || bus.rd_en) begin
      m_is_read   = bus.rd_en && (!bus.wr_en || !m_last_read);
      m_last_read = m_is_read;
      m_in_flight = 1;
      m_age       = 0;
      e_busy      = 1;
      if (m_is_read) begin
        e_addr = bus.rd_addr;
        e_rd   = 1;
      end else begin
        e_addr  = bus.wr_addr;
        e_wdata = bus.wr_data;
        e_strb  = bus.wr_strb;
        e_wr    = 1;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("busy",      32'(bus.busy),      32'(e_busy));
    checkOutput("reg_wr",    32'(bus.reg_wr),    32'(e_wr));
    checkOutput("reg_rd",    32'(bus.reg_rd),    32'(e_rd));
    checkOutput("reg_addr",  32'(bus.reg_addr),  32'(e_addr));
    checkOutput("reg_wdata", bus.reg_wdata,      e_wdata);
    checkOutput("reg_strb",  32'(bus.reg_strb),  32'(e_strb));
    checkOutput("wr_ack",    32'(bus.wr_ack),    32'(e_wr_ack));
    checkOutput("wr_err",    32'(bus.wr_err),    32'(e_wr_err));
    checkOutput("rd_ack",    32'(bus.rd_ack),    32'(e_rd_ack));
    checkOutput("rd_err",    32'(bus.rd_err),    32'(e_rd_err));
    checkOutput("rd_data",   bus.rd_data,        e_rd_data);
  end

  // Expected {reg_wr, reg_rd, wr_ack, rd_ack} in cycles 1..8 of a held tie.
  logic [3:0] tie_tbl [8] = '{4'b1000, 4'b0010, 4'b0000, 4'b0100,
                              4'b0001, 4'b0000, 4'b1000, 4'b0010};

  initial begin
    int n;
    int ack_pct;
    logic nwe, nre;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    applyStimulus(0, '0, '0, '0, 0, '0, 0, '0);
    repeat (2) tick();
    checkOutput("rst_busy",    32'(bus.busy),   32'd0);
    checkOutput("rst_reg_wr",  32'(bus.reg_wr), 32'd0);
    checkOutput("rst_rd_data", bus.rd_data,     32'd0);
    rst = 1'b0;
    tick();

    // Single write, target acks in cycle 2.
    applyStimulus(1, 4'd3, 32'h1234_5678, 4'hF, 0, '0, 0, '0);
    tick();
    checkOutput("w1_reg_wr_c1",  32'(bus.reg_wr),   32'd1);
    checkOutput("w1_reg_addr",   32'(bus.reg_addr), 32'd3);
    checkOutput("w1_reg_wdata",  bus.reg_wdata,     32'h1234_5678);
    checkOutput("w1_reg_strb",   32'(bus.reg_strb), 32'hF);
    tick();
    checkOutput("w1_reg_wr_c2",  32'(bus.reg_wr),   32'd1);
    bus.reg_ack = 1;
    tick();
    checkOutput("w1_wr_ack_c3",  32'(bus.wr_ack),   32'd1);
    checkOutput("w1_wr_err_c3",  32'(bus.wr_err),   32'd0);
    applyStimulus(0, '0, '0, '0, 0, '0, 0, '0);
    tick();
    checkOutput("w1_busy_c4",    32'(bus.busy),     32'd0);

    // Single read with immediate ack.
    applyStimulus(0, '0, '0, '0, 1, 4'd5, 1, 32'hCAFE_0001);
    tick();
    checkOutput("r1_reg_rd_c1",  32'(bus.reg_rd),   32'd1);
    checkOutput("r1_reg_addr",   32'(bus.reg_addr), 32'd5);
    tick();
    checkOutput("r1_rd_ack_c2",  32'(bus.rd_ack),   32'd1);
    checkOutput("r1_rd_data_c2", bus.rd_data,       32'hCAFE_0001);
    applyStimulus(0, '0, '0, '0, 0, '0, 0, '0);
    tick();
    checkOutput("r1_rd_ack_c3",  32'(bus.rd_ack),   32'd0);
    checkOutput("r1_rd_data_c3", bus.rd_data,       32'hCAFE_0001);

    // Both sides held for three transfers: write, read, write.
    applyStimulus(1, 4'd7, 32'h0000_1111, 4'h3, 1, 4'd9, 1, 32'h0000_00A5);
    for (int c = 0; c < 8; c++) begin
      tick();
      checkOutput($sformatf("tie_c%0d", c + 1),
                  32'({bus.reg_wr, bus.reg_rd, bus.wr_ack, bus.rd_ack}), 32'(tie_tbl[c]));
    end
    applyStimulus(0, '0, '0, '0, 0, '0, 0, '0);
    tick();

    // Read timeout.
    applyStimulus(0, '0, '0, '0, 1, 4'd2, 0, '0);
    tick();
    n = 0;
    while (bus.reg_rd && n < 40) begin n++; tick(); end
    checkOutput("to_rd_strobe_cycles", 32'(n),        32'd16);
    checkOutput("to_rd_ack",           32'(bus.rd_ack), 32'd1);
    checkOutput("to_rd_err",           32'(bus.rd_err), 32'd1);
    checkOutput("to_rd_data",          bus.rd_data,     32'hDEAD_BEEF);
    bus.rd_en = 0;
    tick();

    // Write timeout.
    applyStimulus(1, 4'd4, 32'hAAAA_5555, 4'h5, 0, '0, 0, '0);
    tick();
    n = 0;
    while (bus.reg_wr && n < 40) begin n++; tick(); end
    checkOutput("to_wr_strobe_cycles", 32'(n),        32'd16);
    checkOutput("to_wr_ack",           32'(bus.wr_ack), 32'd1);
    checkOutput("to_wr_err",           32'(bus.wr_err), 32'd1);
    checkOutput("to_wr_keeps_rd_data", bus.rd_data,     32'hDEAD_BEEF);
    bus.wr_en = 0;
    tick();

    // Ack arriving in the same cycle as the timeout.
    applyStimulus(0, '0, '0, '0, 1, 4'd6, 0, '0);
    tick();
    repeat (15) tick();
    bus.reg_ack   = 1;
    bus.reg_rdata = 32'h1357_9BDF;
    tick();
    checkOutput("race_rd_ack",  32'(bus.rd_ack), 32'd1);
    checkOutput("race_rd_err",  32'(bus.rd_err), 32'd0);
    checkOutput("race_rd_data", bus.rd_data,     32'h1357_9BDF);
    applyStimulus(0, '0, '0, '0, 0, '0, 0, '0);
    tick();

    // Reset in the second busy cycle of a write.
    applyStimulus(1, 4'd8, 32'h0F0F_0F0F, 4'h1, 0, '0, 0, '0);
    tick();
    tick();
    rst = 1;
    tick();
    checkOutput("rstmid_reg_wr", 32'(bus.reg_wr), 32'd0);
    checkOutput("rstmid_busy",   32'(bus.busy),   32'd0);
    checkOutput("rstmid_wr_ack", 32'(bus.wr_ack), 32'd0);
    rst = 0;
    applyStimulus(0, '0, '0, '0, 0, '0, 0, '0);
    tick();
    applyStimulus(0, '0, '0, '0, 1, 4'd1, 1, 32'h0BAD_F00D);
    tick();
    tick();
    checkOutput("rstmid_rd_ack",  32'(bus.rd_ack), 32'd1);
    checkOutput("rstmid_rd_data", bus.rd_data,     32'h0BAD_F00D);
    applyStimulus(0, '0, '0, '0, 0, '0, 0, '0);
    tick();
    applyStimulus(1, 4'd2, 32'h2222_2222, 4'hC, 1, 4'd3, 0, '0);
    tick();
    checkOutput("rstmid_tie_wr", 32'(bus.reg_wr), 32'd1);
    checkOutput("rstmid_tie_rd", 32'(bus.reg_rd), 32'd0);
    applyStimulus(0, '0, '0, '0, 0, '0, 1, '0);
    tick();
    bus.reg_ack = 0;
    tick();

    // Randomized traffic with varying target responsiveness.
    for (int blk = 0; blk < 12; blk++) begin
      case (blk % 3)
        0:       ack_pct = 40;
        1:       ack_pct = 10;
        default: ack_pct = 0;
      endcase
      for (int c = 0; c < 150; c++) begin
        nwe = bus.wr_en;
        nre = bus.rd_en;
        if (bus.wr_en) begin
          if ((bus.wr_ack && $urandom_range(0, 9) < 7) || $urandom_range(0, 49) == 0) nwe = 0;
        end else if ($urandom_range(0, 9) < 4) nwe = 1;
        if (bus.rd_en) begin
          if ((bus.rd_ack && $urandom_range(0, 9) < 7) || $urandom_range(0, 49) == 0) nre = 0;
        end else if ($urandom_range(0, 9) < 4) nre = 1;
        applyStimulus(nwe, AW'($urandom), $urandom, 4'($urandom), nre, AW'($urandom),
                      $urandom_range(0, 99) < ack_pct, $urandom);
        rst = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    rst = 0;
    applyStimulus(0, '0, '0, '0, 0, '0, 1, '0);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
